// File: rtl/alu_byte_master.sv
// rtl/alu_byte_master.sv - Byte-serial master that feeds two 32-bit operands to an 8-bit ALU and collects a 32-bit result
// Optional WAIT_DONE timeout enabled by defining ALU_MASTER_TIMEOUT_EN.
module alu_byte_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        op_sub,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] result,
    output logic        err,
    output logic        alu_start,
    output logic        alu_opcode,
    output logic [7:0]  alu_in,
    input  logic        alu_done,
    input  logic [7:0]  alu_out
);

    typedef enum logic [2:0] {IDLE, START, SEND, WAIT_DONE, RECV, RESP} state_t;

    state_t      state, state_n;
    logic [63:0] opnd, opnd_n;          // {op_b, op_a}, sent LSB byte first
    logic [2:0]  idx, idx_n;
    logic [1:0]  cnt, cnt_n;
    logic        req_ready_n, resp_valid_n, err_n, alu_start_n, alu_opcode_n;
    logic [31:0] result_n;
    logic [7:0]  alu_in_n;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef ALU_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] tcnt, tcnt_n;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            opnd       <= '0;
            idx        <= '0;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            err        <= 1'b0;
            result     <= '0;
            alu_start  <= 1'b0;
            alu_opcode <= 1'b0;
            alu_in     <= '0;
`ifdef ALU_MASTER_TIMEOUT_EN
            tcnt       <= '0;
`endif
        end else begin
            state      <= state_n;
            opnd       <= opnd_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            req_ready  <= req_ready_n;
            resp_valid <= resp_valid_n;
            err        <= err_n;
            result     <= result_n;
            alu_start  <= alu_start_n;
            alu_opcode <= alu_opcode_n;
            alu_in     <= alu_in_n;
`ifdef ALU_MASTER_TIMEOUT_EN
            tcnt       <= tcnt_n;
`endif
        end
    end

    always_comb begin
        state_n      = state;
        opnd_n       = opnd;
        idx_n        = idx;
        cnt_n        = cnt;
        resp_valid_n = resp_valid;
        err_n        = err;
        result_n     = result;
        alu_start_n  = 1'b0;
        alu_opcode_n = alu_opcode;
        alu_in_n     = alu_in;
`ifdef ALU_MASTER_TIMEOUT_EN
        tcnt_n       = tcnt;
`endif
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    opnd_n       = {op_b, op_a};
                    alu_opcode_n = op_sub;
                    alu_start_n  = 1'b1;
                    state_n      = START;
                end
            end
            START: begin
                idx_n    = '0;
                alu_in_n = opnd[7:0];
                state_n  = SEND;
            end
            SEND: begin
                if (idx == 3'd7) begin
                    state_n = WAIT_DONE;
`ifdef ALU_MASTER_TIMEOUT_EN
                    tcnt_n  = '0;
`endif
                end else begin
                    idx_n    = idx + 3'd1;
                    alu_in_n = opnd[{idx + 3'd1, 3'b000} +: 8];
                end
            end
            WAIT_DONE: begin
                if (alu_done) begin
                    cnt_n   = '0;
                    state_n = RECV;
                end
`ifdef ALU_MASTER_TIMEOUT_EN
                else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    result_n     = '0;
                    err_n        = 1'b1;
                    resp_valid_n = 1'b1;
                    state_n      = RESP;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
`endif
            end
            RECV: begin
                result_n[{cnt, 3'b000} +: 8] = alu_out;
                if (cnt == 2'd3) begin
                    resp_valid_n = 1'b1;
                    err_n        = 1'b0;
                    state_n      = RESP;
                end else begin
                    cnt_n = cnt + 2'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_n = 1'b0;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        req_ready_n = (state_n == IDLE);
    end

endmodule

// File: tb/tb_alu_byte_master.sv
// tb/tb_alu_byte_master.sv - Scoreboard bench for alu_byte_master with a behavioral byte-serial ALU
module tb_alu_byte_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [31:0] op_a, op_b;
    logic        op_sub;
    logic        resp_valid, resp_ready;
    logic [31:0] result;
    logic        err;
    logic        alu_start, alu_opcode;
    logic [7:0]  alu_in;
    logic        alu_done;
    logic [7:0]  alu_out;

    alu_byte_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .result(result), .err(err),
        .alu_start(alu_start), .alu_opcode(alu_opcode), .alu_in(alu_in),
        .alu_done(alu_done), .alu_out(alu_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_txn    = 0;
    int n_start  = 0;

    logic [32:0] sb_q[$];      // {err, result}
    logic [7:0]  byte_q[$];    // expected alu_in byte stream
    logic        exp_op;
    bit          alu_mute;

    logic [31:0] t_a [4] = '{32'h3F800000, 32'h40400000, 32'h40A00000, 32'h41200000};
    logic [31:0] t_b [4] = '{32'h40000000, 32'h3F800000, 32'h3F800000, 32'h40000000};
    logic        t_s [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] t_r [4] = '{32'h40400000, 32'h40000000, 32'h40C00000, 32'h41000000};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] alu_calc(input logic [31:0] a, input logic [31:0] b, input logic s);
        for (int i = 0; i < 4; i++)
            if (t_a[i] == a && t_b[i] == b && t_s[i] == s) return t_r[i];
        return 32'hDEADBEEF;
    endfunction

    // Behavioral ALU: ticks counted at negedges from the one seeing alu_start
    initial begin
        int          tick;
        logic [63:0] rx;
        logic [31:0] res;
        logic        rx_op;
        logic [7:0]  eb;
        tick = -1; rx = '0; res = '0; rx_op = 1'b0;
        alu_done = 1'b0;
        alu_out  = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tick = -1; alu_done = 1'b0; alu_out = 8'h00;
            end else begin
                if (alu_start) n_start++;
                if (tick < 0) begin
                    if (alu_start) tick = 0;
                end else begin
                    tick++;
                    if (tick >= 1 && tick <= 8) begin
                        eb = (byte_q.size() > 0) ? byte_q.pop_front() : 8'hxx;
                        check("alu_in_byte", {24'h0, alu_in}, {24'h0, eb});
                        check("alu_opcode", {31'h0, alu_opcode}, {31'h0, exp_op});
                        rx[(tick-1)*8 +: 8] = alu_in;
                        if (tick == 1) rx_op = alu_opcode;
                        if (tick == 8) res = alu_calc(rx[31:0], rx[63:32], rx_op);
                    end
                    if (tick == 11 && !alu_mute) alu_done = 1'b1;
                    if (tick >= 12 && tick <= 15) begin
                        alu_done = 1'b0;
                        alu_out  = res[(tick-12)*8 +: 8];
                    end
                    if (tick == 15) tick = -1;
                end
            end
        end
    end

    // Called just after a negedge with the DUT idle; returns at the negedge after the handshake.
    task automatic send_req(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ab;
        ab = {b, a};
        req_valid = 1'b1; op_a = a; op_b = b; op_sub = s;
        exp_op = s;
        for (int i = 0; i < 8; i++) byte_q.push_back(ab[i*8 +: 8]);
        n_txn++;
        check("req_ready_idle", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        req_valid = 1'b0; op_a = $urandom; op_b = $urandom; op_sub = ~s;
        check("req_ready_busy", {31'h0, req_ready}, 32'h0);
    endtask

    task automatic wait_resp(input int exp_lat);
        int          lat;
        logic [32:0] e;
        lat = 0;
        while (!resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 33'hx;
        check("result", result, e[31:0]);
        check("err", {31'h0, err}, {31'h0, e[32]});
    endtask

    task automatic run_txn(input int k, input bit bp);
        logic [31:0] held;
        sb_q.push_back({1'b0, t_r[k]});
        resp_ready = !bp;
        send_req(t_a[k], t_b[k], t_s[k]);
        wait_resp(16);
        if (bp) begin
            held = result;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check("bp_valid", {31'h0, resp_valid}, 32'h1);
                check("bp_result", result, held);
                check("bp_req_ready", {31'h0, req_ready}, 32'h0);
            end
            resp_ready = 1'b1;
        end
        @(negedge clk);
        check("resp_dropped", {31'h0, resp_valid}, 32'h0);
        check("req_ready_back", {31'h0, req_ready}, 32'h1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        byte_q.delete();
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_alu_start"},  {31'h0, alu_start},  32'h0);
        check({tag, "_alu_in"},     {24'h0, alu_in},     32'h0);
        check({tag, "_alu_opcode"}, {31'h0, alu_opcode}, 32'h0);
        check({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'h0);
        check({tag, "_err"},        {31'h0, err},        32'h0);
        check({tag, "_result"},     result,              32'h0);
        check({tag, "_req_ready"},  {31'h0, req_ready},  32'h1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0;
        resp_ready = 1'b0; exp_op = 1'b0; alu_mute = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) run_txn(k, 1'b0);
        run_txn(2, 1'b1);

`ifdef ALU_MASTER_TIMEOUT_EN
        alu_mute = 1'b1;
        sb_q.push_back({1'b1, 32'h0});
        send_req(t_a[0], t_b[0], t_s[0]);
        wait_resp(25);
        @(negedge clk);
        check("to_resp_dropped", {31'h0, resp_valid}, 32'h0);
        alu_mute = 1'b0;
`else
        alu_mute = 1'b1;
        send_req(t_a[0], t_b[0], t_s[0]);
        repeat (40) @(negedge clk);
        check("wait_forever_valid", {31'h0, resp_valid}, 32'h0);
        check("wait_forever_ready", {31'h0, req_ready}, 32'h0);
        do_reset();
        alu_mute = 1'b0;
`endif

        run_txn(3, 1'b0);

        send_req(t_a[1], t_b[1], t_s[1]);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid");
        byte_q.delete();
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_txn(0, 1'b0);
        run_txn(1, 1'b0);

        check("start_pulses", n_start, n_txn);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_byte_master.md
ALU_BYTE_MASTER -- requirements
Module: alu_byte_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, max WAIT_DONE cycles before abort (used only with ALU_MASTER_TIMEOUT_EN).
REQ-002 clk  input  1  clock; all flops rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  host request valid.
REQ-005 req_ready  output  1  high in IDLE only.
REQ-006 op_a  input  32  operand A (IEEE-754 single), captured on request handshake.
REQ-007 op_b  input  32  operand B, captured on request handshake.
REQ-008 op_sub  input  1  0 = add, 1 = subtract; captured on request handshake.
REQ-009 resp_valid  output  1  result valid; held until resp_ready.
REQ-010 resp_ready  input  1  host accepts response.
REQ-011 result  output  32  assembled ALU result; stable while resp_valid.
REQ-012 err  output  1  timeout flag, qualified by resp_valid.
REQ-013 alu_start  output  1  one-cycle start pulse to ALU.
REQ-014 alu_opcode  output  1  captured op_sub; held from START through RECV.
REQ-015 alu_in  output  8  byte lane to ALU.
REQ-016 alu_done  input  1  ALU done pulse.
REQ-017 alu_out  input  8  byte lane from ALU.

Function
REQ-018 States: IDLE, START, SEND, WAIT_DONE, RECV, RESP; all outputs registered.
REQ-019 IDLE: on req_valid&&req_ready latch op_a/op_b/op_sub, -> START; alu_start=1 for the START cycle only.
REQ-020 START -> SEND (idx=0); at that edge alu_start<=0, alu_in<=op_a[7:0].
REQ-021 SEND: idx 0..7 drives bytes A[7:0],A[15:8],A[23:16],A[31:24],B[7:0],B[15:8],B[23:16],B[31:24], one per cycle; after idx 7 -> WAIT_DONE; alu_in holds last byte afterwards.
REQ-022 WAIT_DONE: alu_done sampled 1 at edge E -> RECV (cnt=0); alu_done ignored in all other states.
REQ-023 RECV: capture alu_out into result byte cnt at edges E+1..E+4 (LSB first), cnt 0..3; after cnt 3 -> RESP with resp_valid=1, err=0.
REQ-024 Nominal latency: resp_valid rises 16 cycles after request handshake edge.
REQ-025 RESP: resp_valid&&resp_ready -> IDLE, resp_valid<=0; result/err hold until next response.
REQ-026 req_valid in any non-IDLE state ignored (req_ready=0); op_* changes mid-transaction have no effect.
REQ-027 alu_opcode constant from START through last RECV capture; may change only at a new handshake.
REQ-028 Back-to-back: req_ready reasserts the cycle after the response handshake; no overlap of transactions.

Reset
REQ-029 rst_n low: state=IDLE, alu_start=0, alu_in=0, alu_opcode=0, resp_valid=0, err=0, result=0, counters=0, immediately and asynchronously.
REQ-030 Reset mid-transaction abandons it; no resp_valid produced for it; host must also reset ALU.

Configuration
REQ-031 Macro ALU_MASTER_TIMEOUT_EN defined: cycle counter cleared on WAIT_DONE entry; if alu_done not seen within TIMEOUT_CYCLES cycles -> RESP with err=1, result=0.
REQ-032 Macro undefined: no counter, WAIT_DONE waits indefinitely, err constant 0.

Verification
REQ-033 Add: op_a=3F800000, op_b=40000000, op_sub=0 -> alu_in bytes 00,00,80,3F,00,00,00,40; behavioral ALU returns 40400000; result=40400000, err=0, resp_valid 16 cycles after accept.
REQ-034 Sub: op_a=40400000, op_b=3F800000, op_sub=1 -> alu_opcode=1 throughout; result=40000000.
REQ-035 Back-pressure: resp_ready low 5 cycles -> resp_valid/result stable, req_ready=0; then handshake -> IDLE, req_ready=1 next cycle.
REQ-036 Timeout (macro on, TIMEOUT_CYCLES=16): alu_done tied 0 -> resp_valid with err=1, result=0 after 16 WAIT_DONE cycles; macro off -> stays in WAIT_DONE.
REQ-037 Reset at SEND idx 3 -> all outputs reset values at once; new request then completes correctly with err=0.
REQ-038 Two back-to-back requests with resp_ready=1 -> two correct results, exactly one alu_start pulse each.
